// File: rtl/duel_round_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | duel_round_scheduler_if : player inputs and display outputs of the duel  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface duel_round_scheduler_if;
   logic        start;
   logic [15:0] p1_traced;
   logic [15:0] p2_traced;
   logic        p1_submit;
   logic        p2_submit;
   logic [15:0] target_trace;
   logic        trace_screen_on;
   logic [7:0]  time_left;
   logic [1:0]  round_winner;
   logic [2:0]  p1_score;
   logic [2:0]  p2_score;
   logic        game_over;
   logic [1:0]  winner;

   modport master (
      output start, p1_traced, p2_traced, p1_submit, p2_submit,
      input  target_trace, trace_screen_on, time_left, round_winner,
             p1_score, p2_score, game_over, winner
   );

   modport slave (
      input  start, p1_traced, p2_traced, p1_submit, p2_submit,
      output target_trace, trace_screen_on, time_left, round_winner,
             p1_score, p2_score, game_over, winner
   );
endinterface
`default_nettype wire

// File: rtl/duel_round_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | duel_round_scheduler : round sequencing, trace judging and scoring       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module duel_round_scheduler #(
   parameter int unsigned TICKS_PER_SEC = 50000000,
   parameter int unsigned ROUND_SECS    = 10,
   parameter int unsigned SHOW_TICKS    = 25000000,
   parameter int unsigned RESULT_TICKS  = 50000000,
   parameter int unsigned WIN_SCORE     = 3
) (
   input  wire logic                    clk,
   input  wire logic                    resetn,
   duel_round_scheduler_if.slave        bus
);

   localparam int unsigned c_PHASE_MAX = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
   localparam int          c_PHASE_W   = (c_PHASE_MAX > 1) ? $clog2(c_PHASE_MAX) : 1;
   localparam int          c_TICK_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [c_PHASE_W-1:0] c_SHOW_LAST   = c_PHASE_W'(SHOW_TICKS - 1);
   localparam logic [c_PHASE_W-1:0] c_RESULT_LAST = c_PHASE_W'(RESULT_TICKS - 1);
   localparam logic [c_TICK_W-1:0]  c_TICK_LAST   = c_TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [7:0]           c_ROUND_SECS  = 8'(ROUND_SECS);
   localparam logic [2:0]           c_WIN         = 3'(WIN_SCORE);

   localparam logic [15:0] c_SPELL [8] = '{
      16'h0660, 16'hF99F, 16'h0CCF, 16'hE237,
      16'h1364, 16'h8421, 16'h1248, 16'hFFFF
   };

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SHOW   = 3'd1,
      S_TRACE  = 3'd2,
      S_RESULT = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t               r_state;
   logic [2:0]           r_idx;
   logic [c_PHASE_W-1:0] r_phase_cnt;
   logic [c_TICK_W-1:0]  r_tick_cnt;
   logic                 r_p1_lock;
   logic                 r_p2_lock;
   logic [15:0]          r_target;
   logic                 r_trace_on;
   logic [7:0]           r_time_left;
   logic [1:0]           r_round_winner;
   logic [2:0]           r_p1_score;
   logic [2:0]           r_p2_score;
   logic                 r_game_over;
   logic [1:0]           r_winner;

   logic       w_p1_match, w_p2_match;
   logic       w_p1_ok, w_p2_ok;
   logic       w_p1_bad, w_p2_bad;
   logic       w_sec_wrap, w_timeout;
   logic [2:0] w_next_idx;

   // Extra set bits in a trace are allowed; only the target's bits must be present.
   assign w_p1_match = (bus.p1_traced & r_target) == r_target;
   assign w_p2_match = (bus.p2_traced & r_target) == r_target;
   assign w_p1_ok    = bus.p1_submit && !r_p1_lock && w_p1_match;
   assign w_p2_ok    = bus.p2_submit && !r_p2_lock && w_p2_match;
   assign w_p1_bad   = bus.p1_submit && !r_p1_lock && !w_p1_match;
   assign w_p2_bad   = bus.p2_submit && !r_p2_lock && !w_p2_match;
   assign w_sec_wrap = (r_tick_cnt == c_TICK_LAST);
   assign w_timeout  = w_sec_wrap && (r_time_left == 8'd1);
   assign w_next_idx = r_idx + 3'd3;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= S_IDLE;
         r_idx          <= 3'd0;
         r_phase_cnt    <= '0;
         r_tick_cnt     <= '0;
         r_p1_lock      <= 1'b0;
         r_p2_lock      <= 1'b0;
         r_target       <= 16'h0000;
         r_trace_on     <= 1'b0;
         r_time_left    <= 8'd0;
         r_round_winner <= 2'd0;
         r_p1_score     <= 3'd0;
         r_p2_score     <= 3'd0;
         r_game_over    <= 1'b0;
         r_winner       <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE, S_OVER: begin
               if (bus.start) begin
                  r_state        <= S_SHOW;
                  r_idx          <= 3'd0;
                  r_target       <= c_SPELL[0];
                  r_phase_cnt    <= '0;
                  r_p1_lock      <= 1'b0;
                  r_p2_lock      <= 1'b0;
                  r_round_winner <= 2'd0;
                  r_p1_score     <= 3'd0;
                  r_p2_score     <= 3'd0;
                  r_game_over    <= 1'b0;
                  r_winner       <= 2'd0;
               end
            end

            S_SHOW: begin
               if (r_phase_cnt == c_SHOW_LAST) begin
                  r_state     <= S_TRACE;
                  r_trace_on  <= 1'b1;
                  r_time_left <= c_ROUND_SECS;
                  r_tick_cnt  <= '0;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end

            S_TRACE: begin
               if (w_sec_wrap) begin
                  r_tick_cnt  <= '0;
                  r_time_left <= r_time_left - 8'd1;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
               r_p1_lock <= r_p1_lock | w_p1_bad;
               r_p2_lock <= r_p2_lock | w_p2_bad;

               // Submissions are judged ahead of the lockout and timeout draws.
               if (w_p1_ok || w_p2_ok || (r_p1_lock && r_p2_lock) || w_timeout) begin
                  r_state     <= S_RESULT;
                  r_trace_on  <= 1'b0;
                  r_phase_cnt <= '0;
                  if (w_p1_ok && !w_p2_ok) begin
                     r_round_winner <= 2'd1;
                     r_p1_score     <= (r_p1_score == c_WIN) ? r_p1_score : r_p1_score + 3'd1;
                  end else if (w_p2_ok && !w_p1_ok) begin
                     r_round_winner <= 2'd2;
                     r_p2_score     <= (r_p2_score == c_WIN) ? r_p2_score : r_p2_score + 3'd1;
                  end else begin
                     r_round_winner <= 2'd3;
                  end
               end
            end

            S_RESULT: begin
               if (r_phase_cnt == c_RESULT_LAST) begin
                  if ((r_p1_score == c_WIN) || (r_p2_score == c_WIN)) begin
                     r_state     <= S_OVER;
                     r_game_over <= 1'b1;
                     r_winner    <= (r_p1_score == c_WIN) ? 2'd1 : 2'd2;
                  end else begin
                     r_state        <= S_SHOW;
                     r_idx          <= w_next_idx;
                     r_target       <= c_SPELL[w_next_idx];
                     r_phase_cnt    <= '0;
                     r_p1_lock      <= 1'b0;
                     r_p2_lock      <= 1'b0;
                     r_round_winner <= 2'd0;
                  end
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.target_trace    = r_target;
   assign bus.trace_screen_on = r_trace_on;
   assign bus.time_left       = r_time_left;
   assign bus.round_winner    = r_round_winner;
   assign bus.p1_score        = r_p1_score;
   assign bus.p2_score        = r_p2_score;
   assign bus.game_over       = r_game_over;
   assign bus.winner          = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_duel_round_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_duel_round_scheduler : directed bench for duel_round_scheduler        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_duel_round_scheduler;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   duel_round_scheduler_if bus ();

   duel_round_scheduler #(
      .TICKS_PER_SEC (4),
      .ROUND_SECS    (3),
      .SHOW_TICKS    (2),
      .RESULT_TICKS  (2),
      .WIN_SCORE     (2)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic submit(input logic s1, input logic s2,
                         input logic [15:0] t1, input logic [15:0] t2);
      bus.p1_traced = t1;
      bus.p2_traced = t2;
      bus.p1_submit = s1;
      bus.p2_submit = s2;
      @(negedge clk);
      bus.p1_submit = 1'b0;
      bus.p2_submit = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn        = 1'b0;
      bus.start     = 1'b0;
      bus.p1_traced = 16'h0000;
      bus.p2_traced = 16'h0000;
      bus.p1_submit = 1'b0;
      bus.p2_submit = 1'b0;
      cycles(2);
      check("rst_target", 32'(bus.target_trace), 32'h0000);
      check("rst_trace_on", 32'(bus.trace_screen_on), 32'd0);
      check("rst_time_left", 32'(bus.time_left), 32'd0);
      check("rst_game_over", 32'(bus.game_over), 32'd0);
      resetn = 1'b1;
      cycles(1);
      check("idle_trace_on", 32'(bus.trace_screen_on), 32'd0);

      // Reset while tracing aborts at once
      start_game();
      check("start_target", 32'(bus.target_trace), 32'h0660);
      cycles(2);
      check("trace_open", 32'(bus.trace_screen_on), 32'd1);
      check("trace_time", 32'(bus.time_left), 32'd3);
      cycles(1);
      #2 resetn = 1'b0;
      #1;
      check("async_rst_trace_on", 32'(bus.trace_screen_on), 32'd0);
      check("async_rst_time", 32'(bus.time_left), 32'd0);
      check("async_rst_target", 32'(bus.target_trace), 32'h0000);
      @(negedge clk);
      resetn = 1'b1;

      // Round 0: p1 wins with extra bits set
      start_game();
      check("r0_target", 32'(bus.target_trace), 32'h0660);
      cycles(2);
      submit(1'b1, 1'b0, 16'h1660, 16'h0000);
      check("r0_winner", 32'(bus.round_winner), 32'd1);
      check("r0_p1_score", 32'(bus.p1_score), 32'd1);
      check("r0_trace_off", 32'(bus.trace_screen_on), 32'd0);
      check("r0_time_hold", 32'(bus.time_left), 32'd3);
      cycles(2);
      check("r1_target", 32'(bus.target_trace), 32'hE237);
      check("r1_winner_clr", 32'(bus.round_winner), 32'd0);
      cycles(2);

      // Round 1: simultaneous matching submits draw
      submit(1'b1, 1'b1, 16'hE237, 16'hE237);
      check("r1_draw", 32'(bus.round_winner), 32'd3);
      check("r1_p1_score", 32'(bus.p1_score), 32'd1);
      check("r1_p2_score", 32'(bus.p2_score), 32'd0);
      cycles(2);
      check("r2_target", 32'(bus.target_trace), 32'h1248);
      cycles(2);

      // Round 2: timeout
      check("r2_time3", 32'(bus.time_left), 32'd3);
      cycles(4);
      check("r2_time2", 32'(bus.time_left), 32'd2);
      cycles(4);
      check("r2_time1", 32'(bus.time_left), 32'd1);
      cycles(3);
      check("r2_still_trace", 32'(bus.trace_screen_on), 32'd1);
      cycles(1);
      check("r2_time0", 32'(bus.time_left), 32'd0);
      check("r2_timeout_draw", 32'(bus.round_winner), 32'd3);
      check("r2_trace_off", 32'(bus.trace_screen_on), 32'd0);
      cycles(2);
      check("r3_target", 32'(bus.target_trace), 32'hF99F);
      cycles(2);
      check("r3_time3", 32'(bus.time_left), 32'd3);

      // Round 3: p2 locks out, later p2 submit ignored, p1 wins
      submit(1'b0, 1'b1, 16'h0000, 16'h0000);
      check("r3_lock_pending", 32'(bus.round_winner), 32'd0);
      check("r3_lock_trace", 32'(bus.trace_screen_on), 32'd1);
      submit(1'b0, 1'b1, 16'h0000, 16'hF99F);
      check("r3_p2_ignored", 32'(bus.round_winner), 32'd0);
      check("r3_p2_ign_trace", 32'(bus.trace_screen_on), 32'd1);
      submit(1'b1, 1'b0, 16'hF99F, 16'h0000);
      check("r3_winner", 32'(bus.round_winner), 32'd1);
      check("r3_p1_score", 32'(bus.p1_score), 32'd2);
      check("r3_p2_score", 32'(bus.p2_score), 32'd0);

      // Game over and restart
      cycles(1);
      check("result_not_over", 32'(bus.game_over), 32'd0);
      cycles(1);
      check("game_over", 32'(bus.game_over), 32'd1);
      check("winner_p1", 32'(bus.winner), 32'd1);
      start_game();
      check("restart_p1", 32'(bus.p1_score), 32'd0);
      check("restart_p2", 32'(bus.p2_score), 32'd0);
      check("restart_target", 32'(bus.target_trace), 32'h0660);
      check("restart_over", 32'(bus.game_over), 32'd0);
      check("restart_winner", 32'(bus.winner), 32'd0);

      // Both players lock out: draw one cycle later
      cycles(2);
      submit(1'b1, 1'b1, 16'h0000, 16'h0000);
      check("dbl_lock_pending", 32'(bus.round_winner), 32'd0);
      check("dbl_lock_trace", 32'(bus.trace_screen_on), 32'd1);
      cycles(1);
      check("dbl_lock_draw", 32'(bus.round_winner), 32'd3);
      check("dbl_lock_p1", 32'(bus.p1_score), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
